// File: rtl/smss_pow_engine.sv
// Multi-lane GF(2^6) exponentiation engine, y = x^e per lane, field z^6+z+1.
// Left-to-right square-and-multiply: one squaring plus one conditional multiply per cycle.
module smss_pow_engine #(
  parameter int LANES = 4,
  parameter int EXP_W = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6*LANES-1:0]   x_in,
  input  logic [EXP_W-1:0]     e_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [6*LANES-1:0]   y_out,
  output logic                 busy
);

  localparam int CNT_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXP_W - 1);
  localparam int DW = 6 * LANES;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [5:0] gf_xtime(input logic [5:0] a);
    return {a[4:0], 1'b0} ^ (a[5] ? 6'h03 : 6'h00);
  endfunction

  // Horner evaluation over the bits of b, MSB first.
  function automatic logic [5:0] gf_mul(input logic [5:0] a, input logic [5:0] b);
    logic [5:0] p;
    p = 6'h00;
    for (int i = 5; i >= 0; i--) begin
      p = gf_xtime(p) ^ (b[i] ? a : 6'h00);
    end
    return p;
  endfunction

  function automatic logic [5:0] lane_step(input logic [5:0] acc, input logic [5:0] x,
                                           input logic b);
    logic [5:0] sq;
    sq = gf_mul(acc, acc);
    return b ? gf_mul(sq, x) : sq;
  endfunction

  state_t           state_q, state_d;
  logic [DW-1:0]    xr_q, xr_d;
  logic [EXP_W-1:0] er_q, er_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [DW-1:0]    y_q, y_d;
  logic             busy_q, busy_d;
  logic [DW-1:0]    acc_step_s;

  // One square-and-multiply step for every lane; er_q MSB is the current exponent bit.
  always_comb begin
    acc_step_s = {DW{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      acc_step_s[6*i +: 6] = lane_step(acc_q[6*i +: 6], xr_q[6*i +: 6], er_q[EXP_W-1]);
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    xr_d        = xr_q;
    er_d        = er_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    y_d         = y_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          xr_d    = x_in;
          er_d    = e_in;
          acc_d   = {LANES{6'h01}};
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d = acc_step_s;
        er_d  = er_q << 1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = {CNT_W{1'b0}};
          y_d     = acc_step_s;
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d == S_RUN) || (state_d == S_DONE);
  end

  // State and output registers; reset wins over any handshake on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      xr_q        <= {DW{1'b0}};
      er_q        <= {EXP_W{1'b0}};
      acc_q       <= {DW{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      y_q         <= {DW{1'b0}};
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      xr_q        <= xr_d;
      er_q        <= er_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y_out     = y_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_smss_pow_engine.sv
// Bench for smss_pow_engine: three instances (4x6, 1x6, 4x1) checked every cycle
// against a transaction-level GF(2^6) model, plus hand-computed literal results.
module tb_smss_pow_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_a     [3];
  logic        in_valid_a  [3];
  logic [23:0] x_a         [3];
  logic [5:0]  e_a         [3];
  logic        out_ready_a [3];

  logic        in_ready_a  [3];
  logic        out_valid_a [3];
  logic        busy_a      [3];
  logic [23:0] y_a         [3];

  logic        ir0, ir1, ir2, ov0, ov1, ov2, bz0, bz1, bz2;
  logic [23:0] y0, y2;
  logic [5:0]  y1;

  smss_pow_engine #(.LANES(4), .EXP_W(6)) u_dut0 (
    .clk(clk), .rst_n(rst_n_a[0]), .in_valid(in_valid_a[0]), .in_ready(ir0),
    .x_in(x_a[0]), .e_in(e_a[0]), .out_valid(ov0), .out_ready(out_ready_a[0]),
    .y_out(y0), .busy(bz0));

  smss_pow_engine #(.LANES(1), .EXP_W(6)) u_dut1 (
    .clk(clk), .rst_n(rst_n_a[1]), .in_valid(in_valid_a[1]), .in_ready(ir1),
    .x_in(x_a[1][5:0]), .e_in(e_a[1]), .out_valid(ov1), .out_ready(out_ready_a[1]),
    .y_out(y1), .busy(bz1));

  smss_pow_engine #(.LANES(4), .EXP_W(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n_a[2]), .in_valid(in_valid_a[2]), .in_ready(ir2),
    .x_in(x_a[2]), .e_in(e_a[2][0:0]), .out_valid(ov2), .out_ready(out_ready_a[2]),
    .y_out(y2), .busy(bz2));

  always_comb begin
    in_ready_a[0] = ir0;  in_ready_a[1] = ir1;  in_ready_a[2] = ir2;
    out_valid_a[0] = ov0; out_valid_a[1] = ov1; out_valid_a[2] = ov2;
    busy_a[0] = bz0;      busy_a[1] = bz1;      busy_a[2] = bz2;
    y_a[0] = y0;          y_a[1] = {18'h0, y1}; y_a[2] = y2;
  end

  int n_vec = 0;
  int n_err = 0;

  function automatic int nl(input int k);
    return (k == 1) ? 1 : 4;
  endfunction

  function automatic int ne(input int k);
    return (k == 2) ? 1 : 6;
  endfunction

  // Schoolbook carry-less product, then reduction by z^6+z+1 (0x43).
  function automatic logic [5:0] ref_mul(input logic [5:0] a, input logic [5:0] b);
    logic [10:0] p;
    p = 11'h000;
    for (int i = 0; i < 6; i++) if (b[i]) p = p ^ (11'(a) << i);
    for (int i = 10; i >= 6; i--) if (p[i]) p = p ^ (11'h043 << (i - 6));
    return p[5:0];
  endfunction

  // x^e as e repeated multiplications; x^0 = 1 for every x.
  function automatic logic [5:0] ref_pow(input logic [5:0] x, input int e);
    logic [5:0] r;
    r = 6'h01;
    for (int j = 0; j < e; j++) r = ref_mul(r, x);
    return r;
  endfunction

  function automatic logic [23:0] model_y(input int k, input logic [23:0] x, input logic [5:0] e);
    logic [23:0] r;
    int ee;
    r  = 24'h0;
    ee = int'(e) & ((1 << ne(k)) - 1);
    for (int i = 0; i < nl(k); i++) r[6*i +: 6] = ref_pow(x[6*i +: 6], ee);
    return r;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s inst%0d t=%0t got %h want %h", nm, k, $time, act, exp);
    end
  endtask

  // Transaction-level model: ready/valid phases and per-lane results.
  logic        m_rdy   [3] = '{1'b0, 1'b0, 1'b0};
  logic        m_vld   [3] = '{1'b0, 1'b0, 1'b0};
  logic        m_yzero [3] = '{1'b1, 1'b1, 1'b1};
  int          m_edges [3] = '{0, 0, 0};
  logic [23:0] m_y     [3];
  logic [23:0] m_yout  [3];

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n_a[k]) begin
        m_rdy[k] <= 1'b0; m_vld[k] <= 1'b0; m_edges[k] <= 0;
        m_yout[k] <= 24'h0; m_yzero[k] <= 1'b1;
      end else if (m_vld[k]) begin
        if (out_ready_a[k]) begin
          m_vld[k] <= 1'b0; m_rdy[k] <= 1'b1;
        end
      end else if (m_edges[k] != 0) begin
        if (m_edges[k] == ne(k)) begin
          m_vld[k] <= 1'b1; m_edges[k] <= 0; m_yout[k] <= m_y[k]; m_yzero[k] <= 1'b0;
        end else begin
          m_edges[k] <= m_edges[k] + 1;
        end
      end else if (m_rdy[k] && in_valid_a[k]) begin
        m_rdy[k] <= 1'b0; m_edges[k] <= 1; m_y[k] <= model_y(k, x_a[k], e_a[k]);
      end else begin
        m_rdy[k] <= 1'b1;
      end
    end
  end

  // Compare every instance against the model on each falling edge.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk("in_ready", k, 32'(in_ready_a[k]), 32'(m_rdy[k]));
      chk("out_valid", k, 32'(out_valid_a[k]), 32'(m_vld[k]));
      chk("busy", k, 32'(busy_a[k]), 32'((m_edges[k] != 0) || m_vld[k]));
      if (m_vld[k]) chk("y_out", k, 32'(y_a[k]), 32'(m_yout[k]));
      if (m_yzero[k]) chk("y_zero", k, 32'(y_a[k]), 32'h0);
    end
  end

  task automatic req(input int k, input logic [23:0] x, input int e, input bit lit,
                     input logic [23:0] exp_y, input string nm);
    int t;
    t = 0;
    while (in_ready_a[k] !== 1'b1 && t < 40) begin @(negedge clk); t++; end
    if (t >= 40) chk({nm, "_ready_timeout"}, k, 32'(in_ready_a[k]), 32'h1);
    in_valid_a[k] = 1'b1; x_a[k] = x; e_a[k] = 6'(e);
    @(negedge clk);
    in_valid_a[k] = 1'b0; x_a[k] = 24'($urandom); e_a[k] = 6'($urandom);
    t = 1;
    while (out_valid_a[k] !== 1'b1 && t < 40) begin @(negedge clk); t++; end
    if (t >= 40) chk({nm, "_valid_timeout"}, k, 32'(out_valid_a[k]), 32'h1);
    if (lit) begin
      chk({nm, "_latency"}, k, 32'(t), 32'(ne(k) + 1));
      chk(nm, k, 32'(y_a[k]), 32'(exp_y));
    end
    if (out_ready_a[k]) @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_n_a[k] = 1'b0; in_valid_a[k] = 1'b0; x_a[k] = 24'h0; e_a[k] = 6'h0;
      out_ready_a[k] = 1'b1;
    end
    repeat (3) @(negedge clk);
    chk("rst_y_lit", 0, 32'(y_a[0]), 32'h0);
    chk("rst_ready_lit", 0, 32'(in_ready_a[0]), 32'h0);
    for (int k = 0; k < 3; k++) rst_n_a[k] = 1'b1;

    // Pin the model with hand-derived field facts.
    chk("pin_3pow6", 0, 32'(ref_pow(6'd3, 6)), 32'h16);
    chk("pin_2pow6", 0, 32'(ref_pow(6'd2, 6)), 32'h03);
    chk("pin_inv2", 0, 32'(ref_pow(6'd2, 62)), 32'h21);
    chk("pin_inv21", 0, 32'(ref_pow(6'h21, 62)), 32'h02);
    chk("pin_ord", 0, 32'(ref_pow(6'h05, 63)), 32'h01);
    chk("pin_0pow0", 0, 32'(ref_pow(6'h00, 0)), 32'h01);
    chk("pin_0pow5", 0, 32'(ref_pow(6'h00, 5)), 32'h00);

    @(negedge clk);
    req(0, {6'd1, 6'd0, 6'd3, 6'd2}, 6, 1'b1, {6'd1, 6'd0, 6'h16, 6'd3}, "basic");
    req(0, {6'd0, 6'd1, 6'h21, 6'd2}, 62, 1'b1, {6'd0, 6'd1, 6'd2, 6'h21}, "inverse");
    req(0, {6'd0, 6'd1, 6'h21, 6'd2}, 63, 1'b1, {6'd0, 6'd1, 6'd1, 6'd1}, "order");
    req(0, {6'd2, 6'h3F, 6'd5, 6'd0}, 0, 1'b1, 24'h041041, "zero_exp");
    req(2, {6'h2A, 6'h15, 6'h3F, 6'h07}, 1, 1'b1, {6'h2A, 6'h15, 6'h3F, 6'h07}, "w1_e1");
    req(2, {6'h2A, 6'h00, 6'h3F, 6'h07}, 0, 1'b1, 24'h041041, "w1_e0");
    for (int j = 0; j < 8; j++) req(0, 24'($urandom), int'($urandom_range(0, 63)), 1'b0, 24'h0, "rand");

    // Backpressure: result held, stray requests ignored.
    out_ready_a[0] = 1'b0;
    req(0, {6'h11, 6'h22, 6'h33, 6'h3E}, 45, 1'b1, model_y(0, {6'h11, 6'h22, 6'h33, 6'h3E}, 6'd45), "bp");
    for (int j = 0; j < 10; j++) begin
      in_valid_a[0] = (j == 3) || (j == 4); x_a[0] = 24'hABCDEF; e_a[0] = 6'd7;
      @(negedge clk);
    end
    in_valid_a[0] = 1'b0;
    out_ready_a[0] = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 0, 32'(in_ready_a[0]), 32'h1);

    // Reset while RUN with cnt=3.
    in_valid_a[0] = 1'b1; x_a[0] = 24'h123456; e_a[0] = 6'd59;
    @(negedge clk);
    in_valid_a[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n_a[0] = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 0, 32'(out_valid_a[0]), 32'h0);
    chk("midrst_busy", 0, 32'(busy_a[0]), 32'h0);
    chk("midrst_y", 0, 32'(y_a[0]), 32'h0);
    rst_n_a[0] = 1'b1;
    @(negedge clk);
    req(0, {6'd1, 6'd0, 6'd3, 6'd2}, 6, 1'b1, {6'd1, 6'd0, 6'h16, 6'd3}, "after_rst");

    // Exhaustive single-lane sweep, checked by the model every cycle.
    for (int x = 0; x < 64; x++)
      for (int e = 0; e < 64; e++)
        req(1, 24'(x), e, 1'b0, 24'h0, "exh");

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
